// File: rtl/ps2_mouse_packer.sv
// ps2_mouse_packer
//   Receives the raw PS/2 mouse serial stream and packs every valid 3-byte
//   movement packet onto the 25-bit toggle-strobed MOUSE bus. The block only
//   listens and never drives the PS/2 lines.
//
// Ports:
//   CLK        system clock
//   RESET      asynchronous, active-high reset
//   PS2_CLK_I  raw PS/2 clock line (asynchronous to CLK)
//   PS2_DAT_I  raw PS/2 data line (asynchronous to CLK)
//   MOUSE      [7:0] status, [15:8] dx, [23:16] dy, [24] toggles per packet
//   PKT_ERR    one-cycle pulse for every discarded byte or packet
//
// Parameters:
//   FILT         consecutive equal samples needed to change a filtered level
//   TIMEOUT_CYC  mid-packet idle cycles before the watchdog resynchronises
//
// Build option:
//   PS2_WATCHDOG_EN  when defined, adds the mid-packet idle watchdog.
module ps2_mouse_packer #(
    parameter int unsigned FILT        = 8,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        PS2_CLK_I,
    input  logic        PS2_DAT_I,
    output logic [24:0] MOUSE,
    output logic        PKT_ERR
);

    if (FILT < 2 || FILT > 16) begin : g_bad_filt
        $error("FILT must be in 2..16");
    end
    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 2");
    end

    logic [1:0]      clk_sync_q, dat_sync_q;
    logic [FILT-1:0] clk_shift_q, clk_shift_d, dat_shift_q, dat_shift_d;
    logic            clk_filt_q, clk_filt_d, dat_filt_q, dat_filt_d;
    logic            clk_filt_dly_q;
    logic            fall;

    logic [3:0]      bit_idx_q, bit_idx_d;
    logic [9:0]      frame_q, frame_d;     // [0] start, [8:1] data, [9] parity
    logic [1:0]      byte_idx_q, byte_idx_d;
    logic [7:0]      b0_q, b0_d, b1_q, b1_d;
    logic [24:0]     mouse_q, mouse_d;
    logic            pkt_err_q, pkt_err_d;
    logic [7:0]      byte_data;
    logic            byte_ok;

`ifdef PS2_WATCHDOG_EN
    localparam int unsigned WdW = $clog2(TIMEOUT_CYC);
    localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CYC - 1);
    logic [WdW-1:0] wd_q, wd_d;
`endif

    // Glitch filters: level only moves once the whole window agrees.
    always_comb begin
        clk_shift_d = {clk_shift_q[FILT-2:0], clk_sync_q[1]};
        dat_shift_d = {dat_shift_q[FILT-2:0], dat_sync_q[1]};
        clk_filt_d  = clk_filt_q;
        dat_filt_d  = dat_filt_q;
        if (&clk_shift_d)       clk_filt_d = 1'b1;
        else if (~|clk_shift_d) clk_filt_d = 1'b0;
        if (&dat_shift_d)       dat_filt_d = 1'b1;
        else if (~|dat_shift_d) dat_filt_d = 1'b0;
    end

    assign fall      = clk_filt_dly_q & ~clk_filt_q;
    assign byte_data = frame_q[8:1];
    // Start low, stop (sampled now) high, odd parity over data + parity.
    assign byte_ok   = ~frame_q[0] & dat_filt_q & (^frame_q[9:1]);

    always_comb begin
        bit_idx_d  = bit_idx_q;
        frame_d    = frame_q;
        byte_idx_d = byte_idx_q;
        b0_d       = b0_q;
        b1_d       = b1_q;
        mouse_d    = mouse_q;
        pkt_err_d  = 1'b0;
`ifdef PS2_WATCHDOG_EN
        wd_d       = wd_q;
`endif

        if (fall) begin
            if (bit_idx_q == 4'd10) begin
                bit_idx_d = 4'd0;
                if (!byte_ok) begin
                    byte_idx_d = 2'd0;
                    pkt_err_d  = 1'b1;
                end else begin
                    case (byte_idx_q)
                        2'd0: begin
                            // Status byte always has bit 3 set; use it to resync.
                            if (byte_data[3]) begin
                                b0_d       = byte_data;
                                byte_idx_d = 2'd1;
                            end else begin
                                pkt_err_d = 1'b1;
                            end
                        end
                        2'd1: begin
                            b1_d       = byte_data;
                            byte_idx_d = 2'd2;
                        end
                        2'd2: begin
                            mouse_d    = {~mouse_q[24], byte_data, b1_q, b0_q};
                            byte_idx_d = 2'd0;
                        end
                        default: byte_idx_d = 2'd0;
                    endcase
                end
            end else begin
                frame_d[bit_idx_q] = dat_filt_q;
                bit_idx_d          = bit_idx_q + 4'd1;
            end
        end

`ifdef PS2_WATCHDOG_EN
        // A fall always wins over an expiry in the same cycle.
        if (fall) begin
            wd_d = '0;
        end else if (bit_idx_q != 4'd0 || byte_idx_q != 2'd0) begin
            if (wd_q == WdLast) begin
                wd_d       = '0;
                bit_idx_d  = 4'd0;
                byte_idx_d = 2'd0;
                pkt_err_d  = 1'b1;
            end else begin
                wd_d = wd_q + 1'b1;
            end
        end else begin
            wd_d = '0;
        end
`endif
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            clk_sync_q     <= 2'b11;
            dat_sync_q     <= 2'b11;
            clk_shift_q    <= '1;
            dat_shift_q    <= '1;
            clk_filt_q     <= 1'b1;
            dat_filt_q     <= 1'b1;
            clk_filt_dly_q <= 1'b1;
            bit_idx_q      <= 4'd0;
            frame_q        <= '0;
            byte_idx_q     <= 2'd0;
            b0_q           <= '0;
            b1_q           <= '0;
            mouse_q        <= '0;
            pkt_err_q      <= 1'b0;
        end else begin
            clk_sync_q     <= {clk_sync_q[0], PS2_CLK_I};
            dat_sync_q     <= {dat_sync_q[0], PS2_DAT_I};
            clk_shift_q    <= clk_shift_d;
            dat_shift_q    <= dat_shift_d;
            clk_filt_q     <= clk_filt_d;
            dat_filt_q     <= dat_filt_d;
            clk_filt_dly_q <= clk_filt_q;
            bit_idx_q      <= bit_idx_d;
            frame_q        <= frame_d;
            byte_idx_q     <= byte_idx_d;
            b0_q           <= b0_d;
            b1_q           <= b1_d;
            mouse_q        <= mouse_d;
            pkt_err_q      <= pkt_err_d;
        end
    end

`ifdef PS2_WATCHDOG_EN
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) wd_q <= '0;
        else       wd_q <= wd_d;
    end
`endif

    assign MOUSE   = mouse_q;
    assign PKT_ERR = pkt_err_q;

endmodule

// File: tb/tb_ps2_mouse_packer.sv
// Directed bench for ps2_mouse_packer: drives PS/2 frames bit by bit and
// checks MOUSE / PKT_ERR at exact cycles relative to the stop-bit fall.
module tb_ps2_mouse_packer;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        ps2_clk;
    logic        ps2_dat;
    logic [24:0] MOUSE;
    logic        PKT_ERR;

    int checks   = 0;
    int failures = 0;
    int err_cnt  = 0;
    int tog_cnt  = 0;
    logic prev24 = 1'b0;

    ps2_mouse_packer #(
        .FILT        (8),
        .TIMEOUT_CYC (1000)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .PS2_CLK_I (ps2_clk),
        .PS2_DAT_I (ps2_dat),
        .MOUSE     (MOUSE),
        .PKT_ERR   (PKT_ERR)
    );

    always #5 CLK = ~CLK;

    // Count PKT_ERR cycles and bit-24 toggles outside reset.
    always @(negedge CLK) begin
        if (RESET) begin
            prev24 <= 1'b0;
        end else begin
            if (PKT_ERR) err_cnt <= err_cnt + 1;
            if (MOUSE[24] !== prev24) tog_cnt <= tog_cnt + 1;
            prev24 <= MOUSE[24];
        end
    end

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Set data, hold, then pull the clock low; returns just after the edge
    // at which the low level is driven.
    task automatic drive_bit_low(input logic b);
        @(posedge CLK); #1 ps2_dat = b;
        repeat (19) @(posedge CLK);
        #1 ps2_clk = 1'b0;
    endtask

    task automatic release_clk();
        repeat (20) @(posedge CLK);
        #1 ps2_clk = 1'b1;
    endtask

    // Send the first n bits (start, data LSB first, parity, stop) of a frame.
    task automatic send_head(input logic [7:0] d, input bit bad_par, input int n);
        logic [10:0] fr;
        fr = {1'b1, (~^d) ^ bad_par, d, 1'b0};
        for (int i = 0; i < n; i++) begin
            drive_bit_low(fr[i]);
            release_clk();
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input bit bad_par);
        send_head(d, bad_par, 11);
    endtask

    // Sends all bits up to the stop-bit clock low, then checks the outputs
    // 2 + FILT cycles later (the fall) and one cycle after that.
    task automatic send_last_chk(input string name, input logic [7:0] d, input bit bad_par,
                                 input logic [24:0] old_m, input logic [24:0] new_m,
                                 input logic err);
        send_head(d, bad_par, 10);
        drive_bit_low(1'b1);
        repeat (10) @(posedge CLK);
        @(negedge CLK);
        chk({name, "_pre_mouse"}, {7'd0, MOUSE}, {7'd0, old_m});
        chk({name, "_pre_err"}, {31'd0, PKT_ERR}, 32'd0);
        @(posedge CLK); @(negedge CLK);
        chk({name, "_mouse"}, {7'd0, MOUSE}, {7'd0, new_m});
        chk({name, "_err"}, {31'd0, PKT_ERR}, {31'd0, err});
        @(negedge CLK);
        chk({name, "_err_width"}, {31'd0, PKT_ERR}, 32'd0);
        release_clk();
    endtask

    task automatic send_pkt(input string name, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [24:0] old_m,
                            input logic [24:0] new_m);
        send_byte(b0, 1'b0);
        send_byte(b1, 1'b0);
        send_last_chk(name, b2, 1'b0, old_m, new_m, 1'b0);
    endtask

    initial begin
        int e0;
        RESET   = 1'b1;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        repeat (5) @(posedge CLK);
        @(negedge CLK);
        chk("reset_mouse", {7'd0, MOUSE}, 32'd0);
        chk("reset_err", {31'd0, PKT_ERR}, 32'd0);
        #1 RESET = 1'b0;
        repeat (10) @(posedge CLK);

        send_pkt("pkt1", 8'h08, 8'h05, 8'hFB, 25'h0000000, 25'h1FB0508);
        chk("pkt1_errcnt", err_cnt, 0);
        chk("pkt1_tog", tog_cnt, 1);

        send_pkt("pkt2", 8'h09, 8'h00, 8'h01, 25'h1FB0508, 25'h0010009);
        chk("pkt2_tog", tog_cnt, 2);

        // Bad parity on byte 1, then the trailing 0x10 is a stray status byte.
        send_byte(8'h08, 1'b0);
        send_last_chk("badpar", 8'h10, 1'b1, 25'h0010009, 25'h0010009, 1'b1);
        send_last_chk("stray10", 8'h10, 1'b0, 25'h0010009, 25'h0010009, 1'b1);
        send_pkt("pkt3", 8'h08, 8'h01, 8'h01, 25'h0010009, 25'h1010108);
        chk("pkt3_errcnt", err_cnt, 2);
        chk("pkt3_tog", tog_cnt, 3);

        send_last_chk("stray00", 8'h00, 1'b0, 25'h1010108, 25'h1010108, 1'b1);
        send_pkt("pkt4", 8'h18, 8'h02, 8'h03, 25'h1010108, 25'h0030218);
        chk("pkt4_errcnt", err_cnt, 3);
        chk("pkt4_tog", tog_cnt, 4);

        // Short clock glitches (1..FILT-1 cycles) must be filtered out.
        for (int k = 1; k < 8; k++) begin
            @(posedge CLK); #1 ps2_clk = 1'b0;
            repeat (k) @(posedge CLK);
            #1 ps2_clk = 1'b1;
            repeat (20) @(posedge CLK);
        end
        @(negedge CLK);
        chk("glitch_bitidx", {28'd0, dut.bit_idx_q}, 32'd0);
        chk("glitch_errcnt", err_cnt, 3);
        send_pkt("pkt5", 8'h28, 8'h07, 8'h09, 25'h0030218, 25'h1090728);
        chk("pkt5_tog", tog_cnt, 5);

        // Stall after 1.5 bytes.
        send_byte(8'h08, 1'b0);
        send_head(8'h55, 1'b0, 5);
        e0 = err_cnt;
        repeat (1200) @(posedge CLK);
        @(negedge CLK);
`ifdef PS2_WATCHDOG_EN
        chk("stall_wd_err", err_cnt, e0 + 1);
        send_pkt("pkt_wd", 8'h48, 8'h11, 8'h22, 25'h1090728, 25'h0221148);
        chk("pkt_wd_tog", tog_cnt, 6);
`else
        chk("stall_noerr", err_cnt, e0);
        chk("stall_mouse", {7'd0, MOUSE}, {7'd0, 25'h1090728});
        send_head(8'h00, 1'b0, 3);
`endif

        // Reset in the middle of a frame, then a clean packet from bit 24 = 0.
        #1 RESET = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("midreset_mouse", {7'd0, MOUSE}, 32'd0);
        chk("midreset_bitidx", {28'd0, dut.bit_idx_q}, 32'd0);
        #1 RESET = 1'b0;
        ps2_clk = 1'b1;
        e0 = tog_cnt;
        repeat (10) @(posedge CLK);
        send_pkt("pkt_after_rst", 8'h08, 8'h05, 8'hFB, 25'h0000000, 25'h1FB0508);
        chk("after_rst_tog", tog_cnt, e0 + 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
